// File: rtl/dac_stream_router.sv
// dac_stream_router: double-buffered runtime crossbar from DSP channels to DAC AXI4-Stream masters.
// Define DAC_ROUTER_UNDERRUN_EN to build the per-stream underrun counters.
module dac_stream_router #(
  parameter int NDSP = 9,
  parameter int NDAC = 16,
  parameter int DW   = 256,
  parameter int CNTW = 32,
  parameter int SELW = $clog2(NDSP+1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NDSP*DW-1:0]        dsp_data,
  input  logic [NDSP-1:0]           dsp_valid,
  input  logic                      map_wr,
  input  logic [$clog2(NDAC)-1:0]   map_addr,
  input  logic [SELW-1:0]           map_sel,
  input  logic                      map_commit,
  input  logic                      cnt_clr,
  output logic [NDAC*DW-1:0]        dac_tdata,
  output logic [NDAC-1:0]           dac_tvalid,
  input  logic [NDAC-1:0]           dac_tready,
  output logic [NDAC*CNTW-1:0]      beat_cnt,
  output logic [NDAC*CNTW-1:0]      underrun_cnt,
  output logic [NDAC*SELW-1:0]      map_active
);
  logic [SELW-1:0] shadow [NDAC];
  logic [SELW-1:0] active [NDAC];
  function automatic logic [SELW-1:0] ident(input int j);
    return (j < NDSP) ? SELW'(j) : SELW'(NDSP);
  endfunction
  // Commit samples shadow before a same-cycle write lands, so the write only reaches shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NDAC; j++) begin
        shadow[j] <= ident(j);
        active[j] <= ident(j);
      end
    end else begin
      if (map_commit)
        for (int j = 0; j < NDAC; j++) active[j] <= shadow[j];
      if (map_wr && 32'(map_addr) < NDAC)
        shadow[map_addr] <= map_sel;
    end
  end
  for (genvar j = 0; j < NDAC; j++) begin : g_dac
    logic [DW-1:0]   src_d;
    logic            src_v;
    logic [DW-1:0]   td_q;
    logic            tv_q;
    logic [CNTW-1:0] beat_q;
    logic            mute;
    assign mute = 32'(active[j]) >= NDSP;
    always_comb begin
      src_d = '0;
      src_v = 1'b1;
      for (int k = 0; k < NDSP; k++) begin
        if (active[j] == SELW'(k)) begin
          src_d = dsp_data[k*DW +: DW];
          src_v = dsp_valid[k];
        end
      end
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        td_q <= '0;
        tv_q <= 1'b0;
      end else if (!tv_q || dac_tready[j]) begin
        td_q <= src_d;
        tv_q <= src_v;
      end
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) beat_q <= '0;
      else if (cnt_clr) beat_q <= '0;
      else if (tv_q && dac_tready[j]) beat_q <= beat_q + CNTW'(1);
    end
`ifdef DAC_ROUTER_UNDERRUN_EN
    logic [CNTW-1:0] und_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) und_q <= '0;
      else if (cnt_clr) und_q <= '0;
      else if (dac_tready[j] && !tv_q && !mute && und_q != '1) und_q <= und_q + CNTW'(1);
    end
    assign underrun_cnt[j*CNTW +: CNTW] = und_q;
`else
    assign underrun_cnt[j*CNTW +: CNTW] = '0;
`endif
    assign dac_tdata[j*DW +: DW]       = td_q;
    assign dac_tvalid[j]               = tv_q;
    assign beat_cnt[j*CNTW +: CNTW]    = beat_q;
    assign map_active[j*SELW +: SELW]  = active[j];
  end
endmodule

// File: tb/tb_dac_stream_router.sv
// tb_dac_stream_router: directed plus random stimulus against a cycle-level reference model.
module tb_dac_stream_router;
  localparam int NDSP = 9;
  localparam int NDAC = 16;
  localparam int DW   = 32;
  localparam int CNTW = 8;
  localparam int SELW = $clog2(NDSP+1);
  localparam int AW   = $clog2(NDAC);
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 0;
  logic reset = 1;
  logic [NDSP*DW-1:0]   dsp_data;
  logic [NDSP-1:0]      dsp_valid = '0;
  logic                 map_wr = 0;
  logic [AW-1:0]        map_addr = '0;
  logic [SELW-1:0]      map_sel = '0;
  logic                 map_commit = 0;
  logic                 cnt_clr = 0;
  logic [NDAC*DW-1:0]   dac_tdata;
  logic [NDAC-1:0]      dac_tvalid;
  logic [NDAC-1:0]      dac_tready = '1;
  logic [NDAC*CNTW-1:0] beat_cnt;
  logic [NDAC*CNTW-1:0] underrun_cnt;
  logic [NDAC*SELW-1:0] map_active;

  logic [DW-1:0] dd [NDSP];
  int m_sh [NDAC];
  int m_act [NDAC];
  logic [DW-1:0] m_td [NDAC];
  bit m_tv [NDAC];
  int m_beat [NDAC];
  int m_und [NDAC];
  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  always_comb
    for (int k = 0; k < NDSP; k++) dsp_data[k*DW +: DW] = dd[k];

  dac_stream_router #(.NDSP(NDSP), .NDAC(NDAC), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .dsp_data(dsp_data), .dsp_valid(dsp_valid),
    .map_wr(map_wr), .map_addr(map_addr), .map_sel(map_sel), .map_commit(map_commit),
    .cnt_clr(cnt_clr), .dac_tdata(dac_tdata), .dac_tvalid(dac_tvalid),
    .dac_tready(dac_tready), .beat_cnt(beat_cnt), .underrun_cnt(underrun_cnt),
    .map_active(map_active)
  );

  task automatic chk(input string tag, input int j, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, j, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NDAC; j++) begin
      m_sh[j] = (j < NDSP) ? j : NDSP;
      m_act[j] = m_sh[j];
      m_td[j] = '0;
      m_tv[j] = 0;
      m_beat[j] = 0;
      m_und[j] = 0;
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < NDAC; j++) begin
      chk("tdata", j, 64'(dac_tdata[j*DW +: DW]), 64'(m_td[j]));
      chk("tvalid", j, 64'(dac_tvalid[j]), 64'(m_tv[j]));
      chk("beat", j, 64'(beat_cnt[j*CNTW +: CNTW]), 64'(m_beat[j]));
      chk("underrun", j, 64'(underrun_cnt[j*CNTW +: CNTW]), 64'(m_und[j]));
      chk("map", j, 64'(map_active[j*SELW +: SELW]), 64'(m_act[j]));
    end
  endtask

  // Next state is derived from the rules using pre-edge model state and the current inputs
  task automatic tick();
    int s;
    for (int j = 0; j < NDAC; j++) begin
      if (cnt_clr) begin
        m_beat[j] = 0;
        m_und[j] = 0;
      end else begin
        if (m_tv[j] && dac_tready[j]) m_beat[j] = (m_beat[j] + 1) % (CMAX + 1);
`ifdef DAC_ROUTER_UNDERRUN_EN
        if (dac_tready[j] && !m_tv[j] && m_act[j] < NDSP && m_und[j] < CMAX) m_und[j]++;
`endif
      end
      if (!m_tv[j] || dac_tready[j]) begin
        s = m_act[j];
        m_td[j] = (s < NDSP) ? dd[s] : '0;
        m_tv[j] = (s < NDSP) ? dsp_valid[s] : 1'b1;
      end
    end
    if (map_commit)
      for (int j = 0; j < NDAC; j++) m_act[j] = m_sh[j];
    if (map_wr && int'(map_addr) < NDAC) m_sh[map_addr] = int'(map_sel);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < NDSP; k++) dd[k] = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 0;
    // Identity routing with counting-pattern data
    dsp_valid = '1;
    for (int k = 0; k < NDSP; k++) dd[k] = DW'(k + 1);
    ticks(3);
    chk("dac0_data", 0, 64'(dac_tdata[0 +: DW]), 64'd1);
    chk("dac8_data", 8, 64'(dac_tdata[8*DW +: DW]), 64'd9);
    chk("dac12_mute", 12, 64'(dac_tdata[12*DW +: DW]), 64'd0);
    chk("dac12_valid", 12, 64'(dac_tvalid[12]), 64'd1);
    // Shadow writes without commit, then commit
    map_wr = 1; map_addr = 0; map_sel = 5; tick();
    map_addr = 3; map_sel = 12; tick();
    map_wr = 0; ticks(2);
    chk("dac0_precommit", 0, 64'(dac_tdata[0 +: DW]), 64'd1);
    map_commit = 1; tick();
    map_commit = 0; tick();
    chk("dac0_switched", 0, 64'(dac_tdata[0 +: DW]), 64'd6);
    chk("dac3_muted", 3, 64'(dac_tdata[3*DW +: DW]), 64'd0);
    ticks(2);
    // Same-cycle write and commit
    map_wr = 1; map_addr = 1; map_sel = 7; map_commit = 1; tick();
    map_wr = 0; map_commit = 0;
    chk("map1_after_same_cycle", 1, 64'(map_active[1*SELW +: SELW]), 64'd1);
    map_commit = 1; tick();
    map_commit = 0;
    chk("map1_after_recommit", 1, 64'(map_active[1*SELW +: SELW]), 64'd7);
    // Stall DAC2 with changing data
    dac_tready[2] = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NDSP; k++) dd[k] = $urandom;
      tick();
    end
    dac_tready[2] = 1;
    for (int k = 0; k < NDSP; k++) dd[k] = $urandom;
    ticks(3);
    // Underrun on DAC4 then clear during a beat
    dsp_valid[4] = 0; ticks(21);
`ifdef DAC_ROUTER_UNDERRUN_EN
    chk("und4_20", 4, 64'(underrun_cnt[4*CNTW +: CNTW]), 64'd20);
`else
    chk("und4_off", 4, 64'(underrun_cnt[4*CNTW +: CNTW]), 64'd0);
`endif
    dsp_valid[4] = 1;
    cnt_clr = 1; tick();
    cnt_clr = 0;
    chk("beat5_clr", 5, 64'(beat_cnt[5*CNTW +: CNTW]), 64'd0);
    // Long underrun on DAC2 to reach saturation, beat counters wrap meanwhile
    dsp_valid[2] = 0; ticks(CMAX + 8);
`ifdef DAC_ROUTER_UNDERRUN_EN
    chk("und2_sat", 2, 64'(underrun_cnt[2*CNTW +: CNTW]), 64'(CMAX));
`endif
    dsp_valid[2] = 1; tick();
    // Random traffic with map updates and occasional clears
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NDSP; k++) dd[k] = $urandom;
      dsp_valid = NDSP'($urandom);
      dac_tready = NDAC'($urandom);
      map_wr = ($urandom % 4) == 0;
      map_addr = AW'($urandom);
      map_sel = SELW'($urandom);
      map_commit = ($urandom % 8) == 0;
      cnt_clr = ($urandom % 60) == 0;
      tick();
    end
    map_wr = 0; cnt_clr = 0; dac_tready = '1; dsp_valid = '1;
    map_commit = 1; tick();
    map_commit = 0; ticks(2);
    // Asynchronous reset mid-stream
    #2 reset = 1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 0;
    ticks(4);
    chk("dac1_after_reset", 1, 64'(dac_tdata[1*DW +: DW]), 64'(dd[1]));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/dac_stream_router.md
# dac_stream_router

Parametrised, runtime-programmable crossbar between the DSP channel outputs and the RFDC DAC AXI4-Stream inputs, replacing the fixed per-tile channel assignment in the board configuration layer. Each of NDAC output streams selects any of NDSP DSP channels (or mute) from a double-buffered mapping table that is committed atomically. Each output has a one-stage registered AXI4-Stream master, a per-stream accepted-beat counter and, optionally, an underrun counter. Sits in the dspclk domain between `ifdsp` DAC data and the `dacXXaxis` interfaces.

## Interface
Parameters:
- NDSP, 9, number of DSP source channels
- NDAC, 16, number of DAC output streams
- DW, 256, data width per channel (bits)
- CNTW, 32, width of beat/underrun counters
- SELW, $clog2(NDSP+1), width of one map entry

Ports:
- clk  in  1  dspclk
- reset  in  1  asynchronous, active-high
- dsp_data  in  NDSP*DW  source samples, channel k at [k*DW+:DW]
- dsp_valid  in  NDSP  per-source valid
- map_wr  in  1  write strobe, shadow map entry
- map_addr  in  $clog2(NDAC)  DAC index to write
- map_sel  in  SELW  source index; values >= NDSP mean mute
- map_commit  in  1  copy shadow map to active map
- cnt_clr  in  1  clear all counters
- dac_tdata  out  NDAC*DW  stream data, DAC j at [j*DW+:DW]
- dac_tvalid  out  NDAC  stream valid
- dac_tready  in  NDAC  stream ready
- beat_cnt  out  NDAC*CNTW  accepted beats per DAC
- underrun_cnt  out  NDAC*CNTW  underrun cycles per DAC
- map_active  out  NDAC*SELW  readback of active map

## Operation
- Shadow and active maps reset to identity: entry j = j for j < NDSP, else NDSP (mute).
- map_wr writes shadow[map_addr] <= map_sel; map_addr >= NDAC ignored.
- map_commit copies whole shadow to active in one cycle; all outputs switch on the same edge.
- Same-cycle map_wr and map_commit: commit copies shadow as it was before the write; the write lands in shadow only.
- Per DAC j, with s = active[j]: output register loads when (!dac_tvalid[j] | dac_tready[j]).
  - s < NDSP: tdata <= dsp_data[s], tvalid <= dsp_valid[s].
  - mute: tdata <= 0, tvalid <= 1.
  - If the register is stalled (tvalid=1, tready=0), it holds; source samples during the stall are discarded.
- beat_cnt[j] increments on dac_tvalid[j] & dac_tready[j]; wraps modulo 2^CNTW.
- underrun_cnt[j] increments on cycles with dac_tready[j]=1, dac_tvalid[j]=0 and active[j] not mute; saturates at 2^CNTW-1.
- cnt_clr zeroes all counters; clear wins over a same-cycle increment.
- Mid-operation reset: all outputs immediately return to reset values; maps return to identity.

## Timing
- Reset values: dac_tdata 0, dac_tvalid 0, beat_cnt 0, underrun_cnt 0, map_active identity.
- Data latency 1 cycle: dsp_data at edge n appears on dac_tdata after edge n+1 (unstalled).
- map_wr at cycle n visible in shadow at n+1; map_commit at n updates map_active at n+1; new source appears on dac_tdata at n+2.
- Counters update 1 cycle after the qualifying condition; cnt_clr takes effect at the next edge.
- No combinational path from dac_tready to any output.

## Configuration
- DAC_ROUTER_UNDERRUN_EN defined: underrun counters built as above.
- Undefined: no underrun logic; underrun_cnt tied to 0; all other behaviour unchanged.

## Test plan
- Reset, then NDSP=9/NDAC=16, all tready=1, dsp_valid=all-ones, dsp_data[k]=k+1 -> DAC j<9 outputs j+1 from cycle 2; DAC 9..15 output 0 with tvalid=1.
- Write shadow[0]=5, shadow[3]=12, no commit -> outputs unchanged; commit -> DAC0 carries source 5 and DAC3 muted exactly 2 cycles after commit, all other DACs unchanged on the same edge.
- map_wr (addr 1, sel 7) and map_commit in the same cycle -> map_active[1] stays 1; second commit -> becomes 7.
- Hold dac_tready[2]=0 for 10 cycles with changing source data -> dac_tdata[2] frozen, beat_cnt[2] frozen; release -> newest sample after 1 cycle, beat_cnt[2] resumes.
- dsp_valid[4]=0 for 20 cycles, tready=1, DAC4 unmuted -> underrun_cnt[4]=20 (0 with macro undefined); cnt_clr asserted during a beat -> counters read 0 next cycle.
- Assert reset mid-stream after a commit -> all tvalid 0, counters 0, map_active identity within the same cycle (async), normal flow 2 cycles after deassertion.
